// File: rtl/dozen_pkg.sv
// Shared definitions for the camera dozen path: widths, the packer state
// encoding and the FIFO entry layout ({meta flag, 12-bit dozen}).
// Used by dozen_packer and dozen_fifo (and reusable by dozen_buffer).
package dozen_pkg;

  localparam int DOZEN_W = 12;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    META  = 2'd1,
    PIXEL = 2'd2,
    FLUSH = 2'd3
  } state_e;

  typedef struct packed {
    logic               meta;
    logic [DOZEN_W-1:0] dozen;
  } fifo_entry_t;

endpackage

// File: rtl/dozen_fifo.sv
// Synchronous FIFO of {meta, dozen} entries; head is a registered entry, no fall-through.
// Latency: a push at edge n is visible at the head after edge n.
// Backpressure: pushes while full are dropped unless a pop happens the same cycle.
// Ports: push_i/push_dat_i write side, pop_i read request (ignored when empty),
//        head_dat_o/empty_o/full_o status toward the consumer.
module dozen_fifo
  import dozen_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  fifo_entry_t push_dat_i,
  input  logic        pop_i,
  output fifo_entry_t head_dat_o,
  output logic        empty_o,
  output logic        full_o
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == (AW+1)'(DEPTH));
  assign head_dat_o = mem_q[rd_ptr_q];

  // A pop frees the slot this cycle, so a full FIFO still takes the push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/dozen_packer.sv
// Packs the 8-bit camera byte stream into 12-bit dozens (3 bytes -> 2 dozens),
// tagging each as header (first META_BYTES bytes of a frame) or pixel data.
// Latency: a dozen completed by the byte at edge n is at the FIFO head after edge n.
// Backpressure: none toward the camera; dozens written into a full FIFO are lost (overflow_err).
// Ports: cam_* / frame_* byte input, dozen_* valid/ready output, sticky overflow_err/frame_err
//        cleared by err_clr. Optional DOZEN_PACKER_STATS_EN adds frame_dozen_count.
module dozen_packer
  import dozen_pkg::*;
#(
  parameter int META_BYTES = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BYTE_W-1:0]  cam_data,
  input  logic               cam_byte_valid,
  input  logic               frame_start,
  input  logic               frame_end,
  output logic [DOZEN_W-1:0] dozen_out,
  output logic               dozen_valid,
  input  logic               dozen_ready,
  output logic               metadata_out_flag,
  output logic               pixel_data_out_flag,
  output logic               overflow_err,
  output logic               frame_err,
  input  logic               err_clr
`ifdef DOZEN_PACKER_STATS_EN
  ,
  output logic [CNT_W-1:0]   frame_dozen_count
`endif
);

  localparam int CW = (META_BYTES > 0) ? $clog2(META_BYTES + 1) : 1;

  state_e            state_q, state_d, st_eff;
  logic [1:0]        phase_q, phase_d, ph_eff;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_eff;
  logic [BYTE_W-1:0] hold_q, hold_d;       // last accepted byte of the open group
  logic              grp_meta_q, grp_meta_d;
  logic              take, push, ovf_set, ferr_set;
  fifo_entry_t       push_ent, head;
  logic              fifo_empty, fifo_full;

  always_comb begin
    // frame_start restarts the frame before the same-cycle byte is looked at,
    // so that byte becomes byte 0 of the new frame.
    st_eff  = state_q;
    ph_eff  = phase_q;
    cnt_eff = cnt_q;
    if (frame_start) begin
      st_eff  = (META_BYTES == 0) ? PIXEL : META;
      ph_eff  = 2'd0;
      cnt_eff = '0;
    end

    take     = cam_byte_valid && (st_eff == META || st_eff == PIXEL);
    push     = 1'b0;
    push_ent = '0;
    state_d    = st_eff;
    phase_d    = ph_eff;
    cnt_d      = cnt_eff;
    hold_d     = hold_q;
    grp_meta_d = grp_meta_q;

    if (take) begin
      push_ent.meta = (st_eff == META);
      case (ph_eff)
        2'd1: begin push = 1'b1; push_ent.dozen = {hold_q, cam_data[7:4]}; end
        2'd2: begin push = 1'b1; push_ent.dozen = {hold_q[3:0], cam_data}; end
        default: ;
      endcase
      hold_d     = cam_data;
      grp_meta_d = (st_eff == META);
      phase_d    = (ph_eff == 2'd2) ? 2'd0 : ph_eff + 2'd1;
      if (cnt_eff != CW'(META_BYTES)) cnt_d = cnt_eff + 1'b1;
      if (st_eff == META && cnt_eff == CW'(META_BYTES - 1)) state_d = PIXEL;
      if (frame_end) state_d = FLUSH;
    end else if (st_eff == FLUSH) begin
      // Zero-pad the open group; only reached when no frame_start arrived.
      push_ent.meta = grp_meta_q;
      case (ph_eff)
        2'd1: begin push = 1'b1; push_ent.dozen = {hold_q, 4'h0}; end
        2'd2: begin push = 1'b1; push_ent.dozen = {hold_q[3:0], 8'h00}; end
        default: ;
      endcase
      state_d = IDLE;
      phase_d = 2'd0;
      cnt_d   = '0;
    end

    ferr_set = frame_start && (state_q != IDLE);
    ovf_set  = (push && fifo_full && !dozen_ready) ||
               (cam_byte_valid && st_eff == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= 2'd0;
      cnt_q        <= '0;
      hold_q       <= '0;
      grp_meta_q   <= 1'b0;
      overflow_err <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      grp_meta_q <= grp_meta_d;
      // Clear wins over a same-cycle set.
      if (err_clr) begin
        overflow_err <= 1'b0;
        frame_err    <= 1'b0;
      end else begin
        overflow_err <= overflow_err | ovf_set;
        frame_err    <= frame_err | ferr_set;
      end
    end
  end

  dozen_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .push_dat_i(push_ent),
    .pop_i     (dozen_ready),
    .head_dat_o(head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign dozen_out           = head.dozen;
  assign dozen_valid         = !fifo_empty;
  assign metadata_out_flag   = !fifo_empty && head.meta;
  assign pixel_data_out_flag = !fifo_empty && !head.meta;

`ifdef DOZEN_PACKER_STATS_EN
  // Counts write attempts (including dropped and flush writes) per frame.
  logic [CNT_W-1:0] stat_q, stat_base, stat_d;

  always_comb begin
    stat_base = frame_start ? '0 : stat_q;
    stat_d    = (push && !(&stat_base)) ? stat_base + 1'b1 : stat_base;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_q            <= '0;
      frame_dozen_count <= '0;
    end else begin
      stat_q <= stat_d;
      if (state_q == FLUSH && !frame_start) frame_dozen_count <= stat_d;
    end
  end
`endif

endmodule
